// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encodings, bit indices and cause codes for the trap unit.
// Pure definitions; no timing or flow control.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH = 12'h310;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  localparam logic [4:0] EXC_INSTR_MISALIGN = 5'd0;
  localparam logic [4:0] EXC_INSTR_FAULT    = 5'd1;
  localparam logic [4:0] EXC_ILLEGAL_INSTR  = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
  localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] EXC_LOAD_FAULT     = 5'd5;
  localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
  localparam logic [4:0] EXC_STORE_FAULT    = 5'd7;
  localparam logic [4:0] EXC_ECALL_M        = 5'd11;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_RS: return old_val | wdata;
      CSR_OP_RC: return old_val & ~wdata;
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independent 32-bit half writes; a write suppresses that cycle's increment.
// Count visible one cycle after the increment/write; no backpressure.
module csr_counter64 (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_wr_lo) begin
      r_count <= {r_count[63:32], i_wdata};
    end else if (i_wr_hi) begin
      r_count <= {i_wdata, r_count[31:0]};
    end else if (i_inc) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry, mret and interrupt arbitration; reads combinational, updates next edge.
// Optional counters (mcycle/minstret + user mirrors) enabled by defining CSR_COUNTERS_EN; no backpressure.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [11:0] i_csr_addr,
  input  logic [1:0]  i_csr_op,
  input  logic        i_csr_src_zero,
  input  logic [31:0] i_csr_wdata,
  output logic [31:0] o_csr_rdata,
  output logic        o_csr_illegal,
  input  logic        i_trap_valid,
  input  logic [4:0]  i_trap_cause,
  input  logic [31:0] i_trap_epc,
  input  logic [31:0] i_trap_tval,
  input  logic        i_irq_take,
  input  logic        i_mret_valid,
  input  logic        i_irq_meip,
  input  logic        i_irq_mtip,
  input  logic        i_irq_msip,
  output logic        o_irq_pending,
  output logic [4:0]  o_irq_cause,
  output logic [31:0] o_trap_pc,
  output logic [31:0] o_mret_pc,
  input  logic        i_instr_retire
);

  logic        r_mstatus_mie, r_mstatus_mpie;
  logic [31:0] r_mie, r_mip, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;

  csr_op_e     w_op;
  logic [31:0] w_rdata, w_wval, w_mstatus, w_irq_act, w_mip_next;
  logic        w_impl, w_ro, w_wr_intent, w_csr_we, w_trap, w_is_irq, w_vec;
  logic [4:0]  w_cause;

  assign w_op      = csr_op_e'(i_csr_op);
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle, w_minstret;

  csr_counter64 u_mcycle (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_inc     (1'b1),
    .i_wr_lo   (w_csr_we && i_csr_addr == CSR_MCYCLE),
    .i_wr_hi   (w_csr_we && i_csr_addr == CSR_MCYCLEH),
    .i_wdata   (w_wval),
    .o_count   (w_mcycle)
  );

  csr_counter64 u_minstret (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_inc     (i_instr_retire),
    .i_wr_lo   (w_csr_we && i_csr_addr == CSR_MINSTRET),
    .i_wr_hi   (w_csr_we && i_csr_addr == CSR_MINSTRETH),
    .i_wdata   (w_wval),
    .o_count   (w_minstret)
  );
`else
  logic w_unused_retire;
  assign w_unused_retire = i_instr_retire;
`endif

  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b1;
    w_ro    = 1'b0;
    case (i_csr_addr)
      CSR_MSTATUS:  w_rdata = w_mstatus;
      CSR_MISA:     begin w_rdata = MISA_VAL; w_ro = 1'b1; end
      CSR_MIE:      w_rdata = r_mie;
      CSR_MTVEC:    w_rdata = r_mtvec;
      CSR_MSTATUSH: w_rdata = '0;
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = r_mepc;
      CSR_MCAUSE:   w_rdata = r_mcause;
      CSR_MTVAL:    w_rdata = r_mtval;
      CSR_MIP:      begin w_rdata = r_mip; w_ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_MINSTRET:  w_rdata = w_minstret[31:0];
      CSR_MINSTRETH: w_rdata = w_minstret[63:32];
      CSR_CYCLE:     begin w_rdata = w_mcycle[31:0];     w_ro = 1'b1; end
      CSR_CYCLEH:    begin w_rdata = w_mcycle[63:32];    w_ro = 1'b1; end
      CSR_INSTRET:   begin w_rdata = w_minstret[31:0];   w_ro = 1'b1; end
      CSR_INSTRETH:  begin w_rdata = w_minstret[63:32];  w_ro = 1'b1; end
`endif
      default:      w_impl = 1'b0;
    endcase
  end

  // RS/RC from x0 are pure reads, so they are legal even on read-only CSRs.
  assign w_wr_intent   = (w_op == CSR_OP_RW) ||
                         ((w_op == CSR_OP_RS || w_op == CSR_OP_RC) && !i_csr_src_zero);
  assign o_csr_illegal = (w_op != CSR_OP_NONE) && (!w_impl || (w_ro && w_wr_intent));
  assign w_trap        = i_trap_valid || i_irq_take;
  assign w_csr_we      = w_wr_intent && !o_csr_illegal && !w_trap && !i_mret_valid;
  assign w_wval        = csr_apply(w_op, w_rdata, i_csr_wdata);
  assign o_csr_rdata   = w_rdata;

  assign w_irq_act     = r_mie & r_mip;
  assign o_irq_pending = r_mstatus_mie && (w_irq_act != '0);
  always_comb begin
    o_irq_cause = '0;
    if (w_irq_act[MIP_MEIP])      o_irq_cause = IRQ_MEI;
    else if (w_irq_act[MIP_MSIP]) o_irq_cause = IRQ_MSI;
    else if (w_irq_act[MIP_MTIP]) o_irq_cause = IRQ_MTI;
  end

  // A synchronous exception outranks an interrupt accepted in the same cycle.
  assign w_is_irq  = i_irq_take && !i_trap_valid;
  assign w_cause   = w_is_irq ? o_irq_cause : i_trap_cause;
  assign w_vec     = VECTORED_EN && r_mtvec[0] && w_is_irq;
  assign o_trap_pc = {r_mtvec[31:2], 2'b00} + (w_vec ? {25'b0, w_cause, 2'b00} : 32'd0);
  assign o_mret_pc = r_mepc;

  always_comb begin
    w_mip_next = '0;
    w_mip_next[MIP_MEIP] = i_irq_meip;
    w_mip_next[MIP_MTIP] = i_irq_mtip;
    w_mip_next[MIP_MSIP] = i_irq_msip;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mip          <= '0;
      r_mtvec        <= MTVEC_RST;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else begin
      r_mip <= w_mip_next;
      if (w_trap) begin
        r_mepc         <= i_trap_epc & 32'hFFFF_FFFC;
        r_mcause       <= {w_is_irq, 26'b0, w_cause};
        r_mtval        <= w_is_irq ? 32'd0 : i_trap_tval;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (i_mret_valid) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_csr_we) begin
        case (i_csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_wval[MSTATUS_MIE];
            r_mstatus_mpie <= w_wval[MSTATUS_MPIE];
          end
          CSR_MIE:      r_mie      <= w_wval & MIE_MASK;
          CSR_MTVEC:    r_mtvec    <= {w_wval[31:2], 1'b0, VECTORED_EN ? w_wval[0] : 1'b0};
          CSR_MSCRATCH: r_mscratch <= w_wval;
          CSR_MEPC:     r_mepc     <= w_wval & 32'hFFFF_FFFC;
          CSR_MCAUSE:   r_mcause   <= w_wval;
          CSR_MTVAL:    r_mtval    <= w_wval;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: table of single-cycle CSR accesses plus trap/irq/mret/counter/reset sequences.
module tb_csr_trap_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_src_zero;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_illegal;
  logic        trap_valid, irq_take, mret_valid;
  logic [4:0]  trap_cause, irq_cause;
  logic [31:0] trap_epc, trap_tval, trap_pc, mret_pc;
  logic        meip, mtip, msip, irq_pending, instr_retire;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_trap_unit dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_csr_addr(csr_addr), .i_csr_op(csr_op), .i_csr_src_zero(csr_src_zero),
    .i_csr_wdata(csr_wdata), .o_csr_rdata(csr_rdata), .o_csr_illegal(csr_illegal),
    .i_trap_valid(trap_valid), .i_trap_cause(trap_cause), .i_trap_epc(trap_epc),
    .i_trap_tval(trap_tval), .i_irq_take(irq_take), .i_mret_valid(mret_valid),
    .i_irq_meip(meip), .i_irq_mtip(mtip), .i_irq_msip(msip),
    .o_irq_pending(irq_pending), .o_irq_cause(irq_cause), .o_trap_pc(trap_pc),
    .o_mret_pc(mret_pc), .i_instr_retire(instr_retire)
  );

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic        sz;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_addr = '0; csr_op = 2'd0; csr_src_zero = 1'b0; csr_wdata = '0;
    trap_valid = 1'b0; trap_cause = '0; trap_epc = '0; trap_tval = '0;
    irq_take = 1'b0; mret_valid = 1'b0;
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic sz, input logic [31:0] wd);
    csr_addr = a; csr_op = op; csr_src_zero = sz; csr_wdata = wd;
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr(a, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk(nm, csr_rdata, exp);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; meip = 1'b0; mtip = 1'b0; msip = 1'b0; instr_retire = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_irq_pending", {31'b0, irq_pending}, 32'd0);
    chk("rst_mret_pc", mret_pc, 32'd0);
    chk("rst_trap_pc", trap_pc, 32'd0);
    tick();

    // {addr, op, src_zero, wdata, expected old value, expected illegal}
    vt.push_back('{CSR_MISA,     2'd2, 1'b1, 32'd0,         32'h4000_0100, 1'b0});
    vt.push_back('{CSR_MTVEC,    2'd2, 1'b1, 32'd0,         32'h0,         1'b0});
    vt.push_back('{CSR_MSTATUS,  2'd2, 1'b1, 32'd0,         32'h0000_1800, 1'b0});
    vt.push_back('{CSR_MIE,      2'd2, 1'b1, 32'd0,         32'h0,         1'b0});
    vt.push_back('{CSR_MSCRATCH, 2'd2, 1'b1, 32'd0,         32'h0,         1'b0});
    vt.push_back('{CSR_MEPC,     2'd2, 1'b1, 32'd0,         32'h0,         1'b0});
    vt.push_back('{CSR_MCAUSE,   2'd2, 1'b1, 32'd0,         32'h0,         1'b0});
    vt.push_back('{CSR_MTVAL,    2'd2, 1'b1, 32'd0,         32'h0,         1'b0});
    vt.push_back('{CSR_MIP,      2'd2, 1'b1, 32'd0,         32'h0,         1'b0});
    vt.push_back('{CSR_MSTATUSH, 2'd2, 1'b1, 32'd0,         32'h0,         1'b0});
    vt.push_back('{CSR_MSCRATCH, 2'd1, 1'b0, 32'hDEADBEEF,  32'h0,         1'b0});
    vt.push_back('{CSR_MSCRATCH, 2'd2, 1'b0, 32'h0000000F,  32'hDEADBEEF,  1'b0});
    vt.push_back('{CSR_MSCRATCH, 2'd3, 1'b0, 32'hF0000000,  32'hDEADBEEF,  1'b0});
    vt.push_back('{CSR_MSCRATCH, 2'd3, 1'b1, 32'hFFFFFFFF,  32'h0EADBEEF,  1'b0});
    vt.push_back('{CSR_MSCRATCH, 2'd2, 1'b1, 32'd0,         32'h0EADBEEF,  1'b0});
    vt.push_back('{CSR_MISA,     2'd1, 1'b0, 32'h0,         32'h4000_0100, 1'b1});
    vt.push_back('{CSR_MISA,     2'd2, 1'b1, 32'd0,         32'h4000_0100, 1'b0});
    vt.push_back('{CSR_MIP,      2'd1, 1'b0, 32'hFFFFFFFF,  32'h0,         1'b1});
    vt.push_back('{CSR_MIP,      2'd2, 1'b1, 32'hFFFFFFFF,  32'h0,         1'b0});
    vt.push_back('{12'h7C0,      2'd2, 1'b1, 32'd0,         32'h0,         1'b1});
    vt.push_back('{CSR_MSTATUSH, 2'd1, 1'b0, 32'h5,         32'h0,         1'b0});
    vt.push_back('{CSR_MSTATUSH, 2'd2, 1'b1, 32'd0,         32'h0,         1'b0});
    vt.push_back('{CSR_MEPC,     2'd1, 1'b0, 32'h87,        32'h0,         1'b0});
    vt.push_back('{CSR_MEPC,     2'd2, 1'b1, 32'd0,         32'h84,        1'b0});
    vt.push_back('{CSR_MTVEC,    2'd1, 1'b0, 32'h1001,      32'h0,         1'b0});
    vt.push_back('{CSR_MTVEC,    2'd2, 1'b1, 32'd0,         32'h1001,      1'b0});
    vt.push_back('{CSR_MIE,      2'd1, 1'b0, 32'h888,       32'h0,         1'b0});
    vt.push_back('{CSR_MIE,      2'd2, 1'b1, 32'd0,         32'h888,       1'b0});
    vt.push_back('{CSR_MSTATUS,  2'd1, 1'b0, 32'h8,         32'h0000_1800, 1'b0});
    vt.push_back('{CSR_MSTATUS,  2'd2, 1'b1, 32'd0,         32'h0000_1808, 1'b0});

    for (int i = 0; i < vt.size(); i++) begin
      csr(vt[i].addr, vt[i].op, vt[i].sz, vt[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d_rdata", i), csr_rdata, vt[i].exp_rd);
      chk($sformatf("vec%0d_illegal", i), {31'b0, csr_illegal}, {31'b0, vt[i].exp_ill});
      tick();
    end
    idle();

    // Interrupt latency, priority and vectored entry.
    meip = 1'b1; mtip = 1'b1;
    @(negedge clk);
    chk("irq_lat_same_cycle", {31'b0, irq_pending}, 32'd0);
    tick();
    @(negedge clk);
    chk("irq_pending_next", {31'b0, irq_pending}, 32'd1);
    chk("irq_cause_mei", {27'b0, irq_cause}, 32'd11);
    tick();
    irq_take = 1'b1; trap_epc = 32'h200;
    @(negedge clk);
    chk("irq_trap_pc_vec", trap_pc, 32'h102C);
    tick();
    idle();
    meip = 1'b0; msip = 1'b1;
    csr(CSR_MCAUSE, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("irq_mcause", csr_rdata, 32'h8000_000B);
    chk("irq_masked_after_entry", {31'b0, irq_pending}, 32'd0);
    tick();
    rd_chk("irq_mstatus", CSR_MSTATUS, 32'h0000_1880);
    rd_chk("irq_mtval", CSR_MTVAL, 32'h0);
    rd_chk("irq_mepc", CSR_MEPC, 32'h200);

    mret_valid = 1'b1;
    csr(CSR_MSCRATCH, 2'd1, 1'b0, 32'h1234);
    @(negedge clk);
    chk("mret1_pc", mret_pc, 32'h200);
    tick();
    idle();
    csr(CSR_MSCRATCH, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("mret_drops_csr_write", csr_rdata, 32'h0EADBEEF);
    chk("irq_pending_after_mret", {31'b0, irq_pending}, 32'd1);
    chk("irq_cause_msi_over_mti", {27'b0, irq_cause}, 32'd3);
    tick();
    msip = 1'b0;
    tick();
    @(negedge clk);
    chk("irq_cause_mti", {27'b0, irq_cause}, 32'd7);
    tick();
    mtip = 1'b0;
    tick();
    @(negedge clk);
    chk("irq_cleared", {31'b0, irq_pending}, 32'd0);
    tick();

    // Exception with a competing same-cycle CSR write, then mret.
    trap_valid = 1'b1; trap_cause = 5'd2; trap_epc = 32'h80; trap_tval = 32'h13;
    csr(CSR_MEPC, 2'd1, 1'b0, 32'h5555);
    @(negedge clk);
    chk("exc_trap_pc_direct", trap_pc, 32'h1000);
    tick();
    idle();
    rd_chk("exc_mepc", CSR_MEPC, 32'h80);
    rd_chk("exc_mcause", CSR_MCAUSE, 32'h2);
    rd_chk("exc_mtval", CSR_MTVAL, 32'h13);
    rd_chk("exc_mstatus", CSR_MSTATUS, 32'h0000_1880);
    mret_valid = 1'b1;
    @(negedge clk);
    chk("mret2_pc", mret_pc, 32'h80);
    tick();
    idle();
    rd_chk("mret2_mstatus", CSR_MSTATUS, 32'h0000_1888);

`ifdef CSR_COUNTERS_EN
    csr(CSR_MCYCLE, 2'd1, 1'b0, 32'hFFFF_FFFF);
    tick();
    csr(CSR_MCYCLEH, 2'd1, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    tick();
    csr(CSR_MCYCLEH, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("mcycleh_carry", csr_rdata, 32'd1);
    csr(CSR_MCYCLE, 2'd0, 1'b0, 32'd0);
    #1;
    chk("mcycle_after_wrap", csr_rdata, 32'd1);
    tick();
    instr_retire = 1'b1;
    repeat (3) tick();
    instr_retire = 1'b0;
    rd_chk("minstret", CSR_MINSTRET, 32'd3);
    rd_chk("instret_mirror", CSR_INSTRET, 32'd3);
    csr(CSR_CYCLE, 2'd1, 1'b0, 32'h0);
    @(negedge clk);
    chk("cycle_mirror_write_illegal", {31'b0, csr_illegal}, 32'd1);
    tick();
    idle();
`else
    csr(CSR_MCYCLE, 2'd2, 1'b1, 32'd0);
    @(negedge clk);
    chk("mcycle_unimpl", {31'b0, csr_illegal}, 32'd1);
    tick();
    csr(CSR_INSTRET, 2'd2, 1'b1, 32'd0);
    @(negedge clk);
    chk("instret_unimpl", {31'b0, csr_illegal}, 32'd1);
    tick();
    idle();
`endif

    // Reset in the middle of a write cycle.
    csr(CSR_MSCRATCH, 2'd1, 1'b0, 32'h1111_1111);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midreset_mscratch", csr_rdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    rd_chk("post_reset_mscratch", CSR_MSCRATCH, 32'h0);
    rd_chk("post_reset_mtvec", CSR_MTVEC, 32'h0);
    chk("post_reset_mret_pc", mret_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
